ascon_permutation_sequencer: RTL and testbench

Sequencer for the ASCON permutation. It owns the 320-bit state register and steps it through p^a (12 rounds) or p^b (6 or 8 rounds), one round per clock. Each round goes through an external combinational round datapath: constant addition, substitution_layer, then linear diffusion. The block sits between the ASCON mode FSM, which issues permutation requests, and the round datapath. It supplies the per-round constant and feeds the datapath output back into the state register.

---
 rtl/ascon_permutation_sequencer_if.sv | 23 ++
 rtl/ascon_permutation_sequencer.sv | 100 ++++++++++
 tb/tb_ascon_permutation_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ascon_permutation_sequencer_if.sv
// Request/response and round-datapath signals of the ASCON permutation sequencer.
// The master side is the mode FSM together with the combinational round datapath.
interface ascon_permutation_sequencer_if;
    logic              i_start;
    logic [3:0]        i_num_rounds;
    logic [4:0][63:0]  i_state;
    logic              o_ready;
    logic [7:0]        o_round_constant;
    logic [4:0][63:0]  o_round_state;
    logic [4:0][63:0]  i_round_state;
    logic              o_valid;
    logic [4:0][63:0]  o_state;

    modport master (
        output i_start, i_num_rounds, i_state, i_round_state,
        input  o_ready, o_round_constant, o_round_state, o_valid, o_state
    );

    modport slave (
        input  i_start, i_num_rounds, i_state, i_round_state,
        output o_ready, o_round_constant, o_round_state, o_valid, o_state
    );
endinterface

// File: rtl/ascon_permutation_sequencer.sv
// Steps the 320-bit ASCON state through p^a / p^b, one round per clock, using an
// external combinational round datapath fed with the state and round constant.
module ascon_permutation_sequencer #(
    parameter int NUM_ROUNDS_MAX = 12
) (
    input  logic                          clock,
    input  logic                          reset_n,
    ascon_permutation_sequencer_if.slave  bus
);

    localparam logic [3:0] ROUNDS_MAX = 4'(NUM_ROUNDS_MAX);
    localparam logic [3:0] LAST_IDX   = 4'(NUM_ROUNDS_MAX - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_t;

    fsm_t             fsm_reg;
    logic [3:0]       round_idx_reg;
    logic [4:0][63:0] state_reg;
    logic [4:0][63:0] result_reg;
    logic             ready_reg;
    logic             valid_reg;
    logic [7:0]       constant_reg;

    logic [3:0]       n_eff;
    logic [3:0]       start_idx;

    // Requests longer than the full permutation are clamped; a short request runs
    // the tail of the schedule so the last round always uses the final constant.
    always_comb begin
        n_eff     = (bus.i_num_rounds > ROUNDS_MAX) ? ROUNDS_MAX : bus.i_num_rounds;
        start_idx = ROUNDS_MAX - n_eff;
    end

    function automatic logic [7:0] round_constant(input logic [3:0] idx);
        return {4'hF - idx, idx};
    endfunction

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fsm_reg       <= IDLE;
            round_idx_reg <= '0;
            state_reg     <= '0;
            result_reg    <= '0;
            ready_reg     <= 1'b1;
            valid_reg     <= 1'b0;
            constant_reg  <= 8'h00;
        end else begin
            valid_reg <= 1'b0;
            case (fsm_reg)
                IDLE: begin
                    if (bus.i_start) begin
                        state_reg     <= bus.i_state;
                        round_idx_reg <= start_idx;
                        ready_reg     <= 1'b0;
                        if (n_eff == 4'd0) begin
                            // Zero rounds: the input state is the result.
                            fsm_reg    <= DONE;
                            valid_reg  <= 1'b1;
                            result_reg <= bus.i_state;
                        end else begin
                            fsm_reg      <= RUN;
                            constant_reg <= round_constant(start_idx);
                        end
                    end
                end
                RUN: begin
                    state_reg     <= bus.i_round_state;
                    round_idx_reg <= round_idx_reg + 4'd1;
                    if (round_idx_reg == LAST_IDX) begin
                        fsm_reg      <= DONE;
                        valid_reg    <= 1'b1;
                        result_reg   <= bus.i_round_state;
                        constant_reg <= 8'h00;
                    end else begin
                        constant_reg <= round_constant(round_idx_reg + 4'd1);
                    end
                end
                DONE: begin
                    fsm_reg   <= IDLE;
                    ready_reg <= 1'b1;
                end
                default: begin
                    fsm_reg   <= IDLE;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_ready          = ready_reg;
    assign bus.o_valid          = valid_reg;
    assign bus.o_round_constant = constant_reg;
    assign bus.o_round_state    = state_reg;
    assign bus.o_state          = result_reg;

endmodule

// File: tb/tb_ascon_permutation_sequencer.sv
// Directed bench for the permutation sequencer with a toy round datapath:
// word 2 ^= constant and word 0 += constant, so both order-free sums are hand-checkable.
module tb_ascon_permutation_sequencer;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    ascon_permutation_sequencer_if bus ();

    ascon_permutation_sequencer #(.NUM_ROUNDS_MAX(12)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always_comb begin
        bus.i_round_state    = bus.o_round_state;
        bus.i_round_state[2] = bus.o_round_state[2] ^ {56'h0, bus.o_round_constant};
        bus.i_round_state[0] = bus.o_round_state[0] + {56'h0, bus.o_round_constant};
    end

    logic [7:0] rc_table [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                                  8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

    // Sum of the 12 constants is 0x762, of the last 8 is 0x3FC, of the last 6 is 0x2A3.
    // XOR of the last 12 and last 8 is 0x00, of the last 6 is 0x11.
    localparam logic [319:0] ZERO   = '0;
    localparam logic [319:0] EXP12  = {64'h0, 64'h0, 64'h0, 64'h0, 64'h762};
    localparam logic [319:0] INIT_B = {64'h6, 64'h5, 64'hFF00, 64'hDEADBEEF, 64'h1000};
    localparam logic [319:0] EXP6   = {64'h6, 64'h5, 64'hFF11, 64'hDEADBEEF, 64'h12A3};
    localparam logic [319:0] EXP8   = {64'h6, 64'h5, 64'hFF00, 64'hDEADBEEF, 64'h13FC};
    localparam logic [319:0] INIT_Z = {64'h4, 64'h3, 64'h2, 64'h1, 64'h0123456789ABCDEF};

    int checks = 0;
    int passes = 0;

    task automatic check_eq(input string tag, input logic [319:0] got, input logic [319:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_run(input logic [3:0] n_req, input int n_eff,
                          input logic [319:0] init, input logic [319:0] exp);
        bus.i_start      = 1'b1;
        bus.i_num_rounds = n_req;
        bus.i_state      = init;
        step();
        bus.i_start = 1'b0;
        bus.i_state = {10{$urandom}};
        for (int k = 0; k < n_eff; k++) begin
            check_eq("run_constant", bus.o_round_constant, rc_table[12 - n_eff + k]);
            check_eq("run_busy", bus.o_ready, 1'b0);
            check_eq("run_no_valid", bus.o_valid, 1'b0);
            step();
        end
        check_eq("done_valid", bus.o_valid, 1'b1);
        check_eq("done_busy", bus.o_ready, 1'b0);
        check_eq("done_constant", bus.o_round_constant, 8'h00);
        check_eq("done_state", bus.o_state, exp);
        step();
        check_eq("idle_ready", bus.o_ready, 1'b1);
        check_eq("idle_no_valid", bus.o_valid, 1'b0);
        check_eq("idle_state", bus.o_state, exp);
        $display("run n=%0d n_eff=%0d result word0=%h word2=%h",
                 n_req, n_eff, bus.o_state[0], bus.o_state[2]);
    endtask

    initial begin
        int valids;
        bus.i_start      = 1'b0;
        bus.i_num_rounds = 4'd0;
        bus.i_state      = '0;

        repeat (2) step();
        check_eq("reset_ready", bus.o_ready, 1'b1);
        check_eq("reset_valid", bus.o_valid, 1'b0);
        check_eq("reset_constant", bus.o_round_constant, 8'h00);
        check_eq("reset_round_state", bus.o_round_state, ZERO);
        check_eq("reset_state", bus.o_state, ZERO);
        $display("reset checked");
        reset_n = 1'b1;

        do_run(4'd12, 12, ZERO, EXP12);
        do_run(4'd6, 6, INIT_B, EXP6);
        do_run(4'd8, 8, INIT_B, EXP8);
        do_run(4'd0, 0, INIT_Z, INIT_Z);
        do_run(4'd15, 12, ZERO, EXP12);

        for (int c = 0; c < 20; c++) begin
            check_eq("hold_state", bus.o_state, EXP12);
            check_eq("hold_no_valid", bus.o_valid, 1'b0);
            step();
        end
        $display("hold 20 cycles checked");

        // Continuous start with n=6: accepts at 0, 8, 16; i_state is garbage in between.
        valids = 0;
        bus.i_start      = 1'b1;
        bus.i_num_rounds = 4'd6;
        for (int c = 0; c < 24; c++) begin
            bus.i_state = ((c % 8) == 0) ? INIT_B : {10{$urandom}};
            check_eq("busy_ready", bus.o_ready, ((c % 8) == 0) ? 1'b1 : 1'b0);
            check_eq("busy_valid", bus.o_valid, ((c % 8) == 7) ? 1'b1 : 1'b0);
            if (bus.o_valid) begin
                valids++;
                check_eq("busy_state", bus.o_state, EXP6);
            end
            step();
        end
        bus.i_start = 1'b0;
        check_eq("busy_valid_count", 32'(valids), 32'd3);
        $display("continuous start: %0d results", valids);

        step();
        bus.i_start      = 1'b1;
        bus.i_num_rounds = 4'd12;
        bus.i_state      = ZERO;
        step();
        bus.i_start = 1'b0;
        repeat (5) step();
        check_eq("mid_run_constant", bus.o_round_constant, 8'hA5);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check_eq("abort_ready", bus.o_ready, 1'b1);
        check_eq("abort_constant", bus.o_round_constant, 8'h00);
        check_eq("abort_state", bus.o_state, ZERO);
        check_eq("abort_round_state", bus.o_round_state, ZERO);
        check_eq("abort_valid", bus.o_valid, 1'b0);
        for (int c = 0; c < 14; c++) begin
            check_eq("abort_quiet_valid", bus.o_valid, 1'b0);
            step();
        end
        $display("reset mid-run checked");
        do_run(4'd12, 12, ZERO, EXP12);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
